// File: rtl/scc_dac_pkg.sv
// Shared constants and state type for the SCC sound DAC output stage.
package scc_dac_pkg;

    localparam logic [5:0]  GAIN_MAX   = 6'd32;
    localparam int          GAIN_SHIFT = 5;
    localparam logic [10:0] MIDSCALE   = 11'h400;

    typedef enum logic [1:0] {
        ST_MUTED     = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_UNMUTED   = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } dac_state_e;

endpackage

// File: rtl/scc_dac_dsm1.sv
// First-order 1-bit delta-sigma modulator: the carry out of an 11-bit
// accumulator is the output bit, so ones density tracks level/2048.
module scc_dac_dsm1 (
    input  logic        clk,
    input  logic        nreset,
    input  logic [10:0] level,
    output logic        bit_out
);

    logic [10:0] acc_q, acc_d;
    logic        bit_q, bit_d;
    logic [11:0] sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, level};
        acc_d = sum[10:0];
        bit_d = sum[11];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            acc_q <= 11'd0;
            bit_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            bit_q <= bit_d;
        end
    end

    assign bit_out = bit_q;

endmodule

// File: rtl/scc_sound_dac.sv
// SCC output stage: per-mixer-cycle sample capture, click-free mute gain
// ramp and delta-sigma pin driver.
//
// state        | meaning
// ST_MUTED     | gain held at 0, waiting for mute release
// ST_RAMP_UP   | gain climbing one step per RAMP_DIV clocks toward 32
// ST_UNMUTED   | gain held at 32 (sample passes through unchanged)
// ST_RAMP_DOWN | gain falling one step per RAMP_DIV clocks toward 0
module scc_sound_dac
    import scc_dac_pkg::*;
#(
    parameter int RAMP_DIV = 64
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [2:0]  active,
    input  logic [10:0] sample_in,
    input  logic        mute,
    output logic        dac_out,
    output logic [10:0] level_out,
    output logic        muted,
    output logic [5:0]  gain
);

    localparam int              PW   = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0]   PMAX = PW'(RAMP_DIV - 1);

    dac_state_e      state_q, state_d;
    logic [5:0]      gain_q, gain_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0]      prev_active_q, prev_active_d;
    logic [10:0]     ff_sample_q, ff_sample_d;
    logic [10:0]     level_q, level_d;
    logic            muted_q, muted_d;
    logic            load, step;
    logic signed [16:0] samp_s, gain_s, prod;

    // Capture on the first clock of active==4 only, so a stalled slot counter loads once.
    always_comb begin
        load          = (active == 3'd4) && (prev_active_q != 3'd4);
        prev_active_d = active;
        ff_sample_d   = load ? sample_in : ff_sample_q;
    end

    always_comb begin
        samp_s  = $signed({{6{~ff_sample_q[10]}}, ff_sample_q ^ MIDSCALE});
        gain_s  = $signed({11'd0, gain_q});
        prod    = samp_s * gain_s;
        level_d = 11'(prod >>> GAIN_SHIFT) ^ MIDSCALE;
        muted_d = (state_q == ST_MUTED);
    end

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        presc_d = presc_q;
        step    = (presc_q == PMAX);
        case (state_q)
            ST_MUTED: begin
                gain_d  = 6'd0;
                presc_d = '0;
                if (!mute) state_d = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                presc_d = step ? '0 : presc_q + PW'(1);
                if (mute) begin
                    state_d = ST_RAMP_DOWN;
                end else if (step) begin
                    if (gain_q < GAIN_MAX) gain_d = gain_q + 6'd1;
                    if (gain_d == GAIN_MAX) state_d = ST_UNMUTED;
                end
            end
            ST_UNMUTED: begin
                gain_d  = GAIN_MAX;
                presc_d = '0;
                if (mute) state_d = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
                presc_d = step ? '0 : presc_q + PW'(1);
                if (!mute) begin
                    state_d = ST_RAMP_UP;
                end else if (step) begin
                    if (gain_q != 6'd0) gain_d = gain_q - 6'd1;
                    if (gain_d == 6'd0) state_d = ST_MUTED;
                end
            end
            default: begin
                state_d = ST_MUTED;
                gain_d  = 6'd0;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= ST_MUTED;
            gain_q        <= 6'd0;
            presc_q       <= '0;
            prev_active_q <= 3'd0;
            ff_sample_q   <= MIDSCALE;
            level_q       <= MIDSCALE;
            muted_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            gain_q        <= gain_d;
            presc_q       <= presc_d;
            prev_active_q <= prev_active_d;
            ff_sample_q   <= ff_sample_d;
            level_q       <= level_d;
            muted_q       <= muted_d;
        end
    end

    scc_dac_dsm1 u_dsm (
        .clk     (clk),
        .nreset  (nreset),
        .level   (level_q),
        .bit_out (dac_out)
    );

    assign level_out = level_q;
    assign muted     = muted_q;
    assign gain      = gain_q;

endmodule

// File: tb/tb_scc_sound_dac.sv
// Randomized bench for scc_sound_dac against a behavioural model of the
// capture, gain ramp, gain scaling and modulator density rules.
module tb_scc_sound_dac;

    localparam int DIV = 64;

    logic        clk = 1'b0;
    logic        nreset;
    logic [2:0]  active;
    logic [10:0] sample_in;
    logic        mute;
    logic        dac_out;
    logic [10:0] level_out;
    logic        muted;
    logic [5:0]  gain;

    int n_chk = 0;
    int n_err = 0;

    // model state
    int m_gain, m_presc, m_dir, m_ff, m_prev, m_level, m_acc, m_dac, m_muted;
    bit m_settled;

    scc_sound_dac #(.RAMP_DIV(DIV)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .active    (active),
        .sample_in (sample_in),
        .mute      (mute),
        .dac_out   (dac_out),
        .level_out (level_out),
        .muted     (muted),
        .gain      (gain)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gain = 0; m_presc = 0; m_dir = -1; m_settled = 1'b1;
        m_ff = 'h400; m_prev = 0; m_level = 'h400;
        m_acc = 0; m_dac = 0; m_muted = 1;
    endtask

    task automatic model_step();
        int s, nlevel, nsum, want, tgt;
        bit ld, stp;
        ld     = (active == 3'd4) && (m_prev != 4);
        s      = m_ff - 1024;
        nlevel = ((s * m_gain) >>> 5) + 1024;
        nsum   = m_acc + m_level;
        m_dac  = (nsum >= 2048) ? 1 : 0;
        m_acc  = nsum % 2048;
        m_level = nlevel;
        if (ld) m_ff = int'(sample_in);
        m_prev  = int'(active);
        m_muted = (m_settled && m_gain == 0) ? 1 : 0;
        want = mute ? -1 : 1;
        if (m_settled) begin
            if ((m_gain == 0 && want == 1) || (m_gain == 32 && want == -1)) begin
                m_settled = 1'b0;
                m_dir     = want;
            end
            m_presc = 0;
        end else begin
            stp     = (m_presc == DIV - 1);
            m_presc = stp ? 0 : m_presc + 1;
            if (want != m_dir) begin
                m_dir = want;
            end else if (stp) begin
                m_gain = m_gain + m_dir;
                if (m_gain < 0)  m_gain = 0;
                if (m_gain > 32) m_gain = 32;
                tgt = (m_dir > 0) ? 32 : 0;
                if (m_gain == tgt) begin
                    m_settled = 1'b1;
                    m_presc   = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("level_out", 32'(level_out), 32'(m_level));
        check("dac_out",   32'(dac_out),   32'(m_dac));
        check("muted",     32'(muted),     32'(m_muted));
        check("gain",      32'(gain),      32'(m_gain));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive_rand();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0)     active = 3'($urandom_range(0, 7));
        else if (r > 3) active = (active >= 3'd5) ? 3'd0 : active + 3'd1;
        sample_in = 11'($urandom);
    endtask

    task automatic async_reset_check();
        #2 nreset = 1'b0;
        #1;
        check("rst_level", 32'(level_out), 32'h400);
        check("rst_dac",   32'(dac_out),   32'd0);
        check("rst_muted", 32'(muted),     32'd1);
        check("rst_gain",  32'(gain),      32'd0);
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
    endtask

    initial begin
        int cnt, hold;
        nreset = 1'b0; active = 3'd0; sample_in = 11'h400; mute = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        nreset = 1'b1;

        // muted: full-scale samples must not reach the output
        for (int i = 0; i < 120; i++) begin
            drive_rand();
            sample_in = (i % 2 == 0) ? 11'h7FF : 11'h000;
            cycle();
        end

        // power-up ramp to full gain
        mute = 1'b0;
        for (int i = 0; i < 2200 && !(m_settled && m_gain == 32); i++) begin
            drive_rand();
            cycle();
        end
        check("ramp_full_gain", 32'(gain), 32'd32);
        for (int i = 0; i < 20; i++) begin
            drive_rand();
            cycle();
        end

        // random mute toggling, short holds hit reversals, long holds complete ramps
        for (int k = 0; k < 24; k++) begin
            mute = 1'($urandom);
            hold = ($urandom_range(0, 2) == 0) ? $urandom_range(100, 2300) : $urandom_range(1, 90);
            for (int i = 0; i < hold; i++) begin
                drive_rand();
                cycle();
            end
        end

        // reset in the middle of a ramp, then ramp restarts from zero
        mute = 1'b1;
        for (int i = 0; i < 2200 && !(m_settled && m_gain == 0); i++) begin
            drive_rand();
            cycle();
        end
        mute = 1'b0;
        for (int i = 0; i < 700; i++) begin
            drive_rand();
            cycle();
        end
        async_reset_check();
        for (int i = 0; i < 200; i++) begin
            drive_rand();
            cycle();
        end

        // full gain, then pin level at 0x7FF and at 0x000 for a whole accumulator period
        for (int i = 0; i < 2200 && !(m_settled && m_gain == 32); i++) begin
            drive_rand();
            cycle();
        end
        check("full_gain_again", 32'(gain), 32'd32);
        for (int pass = 0; pass < 2; pass++) begin
            active = 3'd0; cycle();
            active = 3'd4; sample_in = (pass == 0) ? 11'h7FF : 11'h000; cycle();
            active = 3'd0; sample_in = 11'h123; cycle();
            cycle();
            cycle();
            check("const_level", 32'(level_out), (pass == 0) ? 32'h7FF : 32'h000);
            cnt = 0;
            for (int i = 0; i < 2048; i++) begin
                cycle();
                cnt += int'(dac_out);
            end
            check((pass == 0) ? "ones_7ff" : "ones_000", 32'(cnt), (pass == 0) ? 32'd2047 : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
